// File: rtl/ysyx22041405_pkg.sv
// Shared decode constants for the NPC IDU: ALU one-hot codes,
// RV32I opcodes and immediate formats.
package ysyx22041405_pkg;

  localparam logic [7:0] ALUADD    = 8'h80;
  localparam logic [7:0] ALULSHIFT = 8'h40;
  localparam logic [7:0] ALUSLT    = 8'h20;
  localparam logic [7:0] ALURSHIFT = 8'h10;
  localparam logic [7:0] ALUDIRECT = 8'h08;
  localparam logic [7:0] ALUAND    = 8'h04;
  localparam logic [7:0] ALUOR     = 8'h02;
  localparam logic [7:0] ALUXOR    = 8'h01;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_t;

  function automatic logic [7:0] f3_alu(input logic [2:0] f3);
    logic [7:0] op;
    unique case (f3)
      3'b000:  op = ALUADD;
      3'b001:  op = ALULSHIFT;
      3'b010:  op = ALUSLT;
      3'b011:  op = ALUSLT;
      3'b100:  op = ALUXOR;
      3'b101:  op = ALURSHIFT;
      3'b110:  op = ALUOR;
      default: op = ALUAND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ysyx22041405_imm_gen.sv
// Immediate generator: builds the sign-extended immediate
// for the selected RV32I instruction format.
module ysyx22041405_imm_gen
  import ysyx22041405_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [31:7]      i_inst,
  input  imm_t             i_type,
  output logic [WIDTH-1:0] o_imm
);

  logic [31:0] w_imm;

  always_comb begin
    w_imm = '0;
    unique case (i_type)
      IMM_I: w_imm = {{20{i_inst[31]}}, i_inst[31:20]};
      IMM_S: w_imm = {{20{i_inst[31]}}, i_inst[31:25],
                      i_inst[11:7]};
      IMM_B: w_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                      i_inst[30:25], i_inst[11:8], 1'b0};
      IMM_U: w_imm = {i_inst[31:12], 12'b0};
      IMM_J: w_imm = {{11{i_inst[31]}}, i_inst[31],
                      i_inst[19:12], i_inst[20],
                      i_inst[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  assign o_imm = w_imm;

endmodule

// File: rtl/ysyx22041405_idu.sv
// RV32I decode stage: decodes one instruction per handshake and
// holds the ALU control word in a registered valid/ready slot.
module ysyx22041405_idu
  import ysyx22041405_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] PC_RESET = 32'h8000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [WIDTH-1:0] in_pc,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] src1,
  output logic [WIDTH-1:0] src2,
  output logic [7:0]       alu_opcode,
  output logic             alu_sub,
  output logic             alu_unsigned,
  output logic             alu_arith,
  output logic [4:0]       rd,
  output logic             wen,
  output logic             ebreak,
  output logic             illegal
);

  logic [6:0]       w_opc;
  logic [2:0]       w_f3;
  logic [6:0]       w_f7;
  logic [4:0]       w_rd;
  logic             w_shift;
  imm_t             w_imm_type;
  logic [WIDTH-1:0] w_imm;

  assign w_opc    = in_inst[6:0];
  assign w_f3     = in_inst[14:12];
  assign w_f7     = in_inst[31:25];
  assign w_rd     = in_inst[11:7];
  assign w_shift  = (w_f3 == 3'b001) || (w_f3 == 3'b101);
  assign rs1_addr = in_inst[19:15];
  assign rs2_addr = in_inst[24:20];

  assign w_imm_type =
    (w_opc == OP_LUI || w_opc == OP_AUIPC) ? IMM_U :
    (w_opc == OP_STORE) ? IMM_S : IMM_I;

  ysyx22041405_imm_gen #(.WIDTH(WIDTH)) u_imm_gen (
    .i_inst (in_inst[31:7]),
    .i_type (w_imm_type),
    .o_imm  (w_imm)
  );

  logic [7:0]       w_alu;
  logic [WIDTH-1:0] w_src1;
  logic [WIDTH-1:0] w_src2;
  logic             w_sub;
  logic             w_uns;
  logic             w_arith;
  logic             w_wen_raw;
  logic             w_wen;
  logic             w_ebreak;
  logic             w_ill;

  always_comb begin
    w_alu     = '0;
    w_src1    = rs1_data;
    w_src2    = rs2_data;
    w_sub     = 1'b0;
    w_uns     = 1'b0;
    w_arith   = 1'b0;
    w_wen_raw = 1'b0;
    w_ebreak  = 1'b0;
    w_ill     = 1'b0;
    unique case (1'b1)
      w_opc == OP_LUI: begin
        w_alu     = ALUDIRECT;
        w_src1    = '0;
        w_src2    = w_imm;
        w_wen_raw = 1'b1;
      end
      w_opc == OP_AUIPC: begin
        w_alu     = ALUADD;
        w_src1    = in_pc;
        w_src2    = w_imm;
        w_wen_raw = 1'b1;
      end
      (w_opc == OP_JAL) || (w_opc == OP_JALR): begin
        w_alu     = ALUADD;
        w_src1    = in_pc;
        w_src2    = WIDTH'(4);
        w_wen_raw = 1'b1;
      end
      w_opc == OP_LOAD: begin
        w_alu     = ALUADD;
        w_src2    = w_imm;
        w_wen_raw = 1'b1;
      end
      w_opc == OP_STORE: begin
        w_alu  = ALUADD;
        w_src2 = w_imm;
      end
      w_opc == OP_BRANCH: begin
        // BEQ/BNE compare by subtraction, BLTU/BGEU unsigned
        w_alu = ALUSLT;
        w_sub = !w_f3[2];
        w_uns = w_f3[1];
        w_ill = (w_f3[2:1] == 2'b01);
      end
      w_opc == OP_IMM: begin
        w_alu     = f3_alu(w_f3);
        w_src2    = w_shift ? WIDTH'(in_inst[24:20]) : w_imm;
        w_arith   = (w_f3 == 3'b101) && w_f7[5];
        w_uns     = (w_f3 == 3'b011);
        w_wen_raw = 1'b1;
        w_ill     = w_shift &&
                    (({w_f7[6], w_f7[4:0]} != 6'b0) ||
                     ((w_f3 == 3'b001) && w_f7[5]));
      end
      w_opc == OP_OP: begin
        w_alu     = f3_alu(w_f3);
        w_sub     = w_f7[5] && (w_f3 == 3'b000);
        w_arith   = w_f7[5] && (w_f3 == 3'b101);
        w_uns     = (w_f3 == 3'b011);
        w_wen_raw = 1'b1;
        w_ill     = !((w_f7 == 7'h00) ||
                      ((w_f7 == 7'h20) &&
                       ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
      end
      w_opc == OP_SYSTEM: begin
        w_ebreak = (in_inst == INST_EBREAK);
        w_ill    = (in_inst != INST_EBREAK);
      end
      default: w_ill = 1'b1;
    endcase
    if (w_ill) begin
      w_alu   = '0;
      w_sub   = 1'b0;
      w_uns   = 1'b0;
      w_arith = 1'b0;
    end
    w_wen = w_wen_raw && !w_ill && (w_rd != 5'd0);
  end

  logic             r_valid;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_src1;
  logic [WIDTH-1:0] r_src2;
  logic [7:0]       r_alu;
  logic             r_sub;
  logic             r_uns;
  logic             r_arith;
  logic [4:0]       r_rd;
  logic             r_wen;
  logic             r_ebreak;
  logic             r_ill;
  logic             w_accept;

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_pc     <= PC_RESET;
      r_src1   <= '0;
      r_src2   <= '0;
      r_alu    <= '0;
      r_sub    <= 1'b0;
      r_uns    <= 1'b0;
      r_arith  <= 1'b0;
      r_rd     <= '0;
      r_wen    <= 1'b0;
      r_ebreak <= 1'b0;
      r_ill    <= 1'b0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_accept) begin
        r_pc     <= in_pc;
        r_src1   <= w_src1;
        r_src2   <= w_src2;
        r_alu    <= w_alu;
        r_sub    <= w_sub;
        r_uns    <= w_uns;
        r_arith  <= w_arith;
        r_rd     <= w_rd;
        r_wen    <= w_wen;
        r_ebreak <= w_ebreak;
        r_ill    <= w_ill;
      end
    end
  end

  assign out_valid    = r_valid;
  assign out_pc       = r_pc;
  assign src1         = r_src1;
  assign src2         = r_src2;
  assign alu_opcode   = r_alu;
  assign alu_sub      = r_sub;
  assign alu_unsigned = r_uns;
  assign alu_arith    = r_arith;
  assign rd           = r_rd;
  assign wen          = r_wen;
  assign ebreak       = r_ebreak;
  assign illegal      = r_ill;

endmodule

// File: tb/tb_ysyx22041405_idu.sv
// Bench for the IDU: directed literal cases plus random traffic
// checked against a mnemonic-level decode model.
module tb_ysyx22041405_idu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [7:0]  alu_opcode;
  logic        alu_sub;
  logic        alu_unsigned;
  logic        alu_arith;
  logic [4:0]  rd;
  logic        wen;
  logic        ebreak;
  logic        illegal;

  ysyx22041405_idu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inst      (in_inst),
    .in_pc        (in_pc),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .src1         (src1),
    .src2         (src2),
    .alu_opcode   (alu_opcode),
    .alu_sub      (alu_sub),
    .alu_unsigned (alu_unsigned),
    .alu_arith    (alu_arith),
    .rd           (rd),
    .wen          (wen),
    .ebreak       (ebreak),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [7:0]  op;
    logic        sub;
    logic        uns;
    logic        arith;
    logic [4:0]  rd;
    logic        wen;
    logic        eb;
    logic        ill;
    logic        c1;
    logic        c2;
  } pkt_t;

  int   n_pass  = 0;
  int   n_total = 0;
  logic m_valid;
  pkt_t m_pkt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic pkt_t ref_decode(input logic [31:0] ins,
                                      input logic [31:0] pc,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
    pkt_t        p;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic        w;
    logic        ok;
    logic [7:0]  tab [8];
    tab   = '{8'h80, 8'h40, 8'h20, 8'h20, 8'h01, 8'h10, 8'h02, 8'h04};
    opc   = ins[6:0];
    f3    = ins[14:12];
    f7    = ins[31:25];
    imm_i = 32'($signed(ins[31:20]));
    imm_s = 32'($signed({ins[31:25], ins[11:7]}));
    imm_u = ins & 32'hFFFF_F000;
    p     = '0;
    w     = 1'b0;
    p.pc  = pc;
    p.rd  = ins[11:7];
    p.ill = 1'b1;
    case (opc)
      7'h37: begin
        p.ill = 0; p.op = 8'h08; p.s2 = imm_u; p.c2 = 1; w = 1;
      end
      7'h17: begin
        p.ill = 0; p.op = 8'h80; p.s1 = pc; p.s2 = imm_u;
        p.c1 = 1; p.c2 = 1; w = 1;
      end
      7'h6f, 7'h67: begin
        p.ill = 0; p.op = 8'h80; p.s1 = pc; p.s2 = 32'd4;
        p.c1 = 1; p.c2 = 1; w = 1;
      end
      7'h03: begin
        p.ill = 0; p.op = 8'h80; p.s1 = a; p.s2 = imm_i;
        p.c1 = 1; p.c2 = 1; w = 1;
      end
      7'h23: begin
        p.ill = 0; p.op = 8'h80; p.s1 = a; p.s2 = imm_s;
        p.c1 = 1; p.c2 = 1;
      end
      7'h63: if (f3 != 3'd2 && f3 != 3'd3) begin
        p.ill = 0; p.op = 8'h20; p.s1 = a; p.s2 = b;
        p.sub = (f3 < 3'd4); p.uns = (f3 >= 3'd6);
        p.c1 = 1; p.c2 = 1;
      end
      7'h13: begin
        if (f3 == 3'd1)      ok = (f7 == 7'h00);
        else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
        else                 ok = 1'b1;
        w = 1;
        if (ok) begin
          p.ill = 0; p.op = tab[f3]; p.s1 = a;
          p.s2 = (f3 == 3'd1 || f3 == 3'd5) ? 32'(ins[24:20]) : imm_i;
          p.arith = (f3 == 3'd5) && (f7 == 7'h20);
          p.uns = (f3 == 3'd3);
          p.c1 = 1; p.c2 = 1;
        end
      end
      7'h33: begin
        ok = (f7 == 7'h00) ||
             ((f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5));
        w = 1;
        if (ok) begin
          p.ill = 0; p.op = tab[f3]; p.s1 = a; p.s2 = b;
          p.sub = (f7 == 7'h20) && (f3 == 3'd0);
          p.arith = (f7 == 7'h20) && (f3 == 3'd5);
          p.uns = (f3 == 3'd3);
          p.c1 = 1; p.c2 = 1;
        end
      end
      7'h73: if (ins == 32'h0010_0073) begin
        p.ill = 0; p.eb = 1;
      end
      default: ;
    endcase
    p.wen = w && !p.ill && (p.rd != 5'd0);
    return p;
  endfunction

  function automatic pkt_t reset_pkt();
    pkt_t p;
    p    = '0;
    p.pc = 32'h8000_0000;
    return p;
  endfunction

  task automatic compare();
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_pc", out_pc, m_pkt.pc);
      chk("alu_opcode", alu_opcode, m_pkt.op);
      chk("alu_sub", alu_sub, m_pkt.sub);
      chk("alu_unsigned", alu_unsigned, m_pkt.uns);
      chk("alu_arith", alu_arith, m_pkt.arith);
      chk("rd", rd, m_pkt.rd);
      chk("wen", wen, m_pkt.wen);
      chk("ebreak", ebreak, m_pkt.eb);
      chk("illegal", illegal, m_pkt.ill);
      chk("onehot", 32'($onehot(alu_opcode) || ebreak || illegal), 1);
      if (m_pkt.c1) chk("src1", src1, m_pkt.s1);
      if (m_pkt.c2) chk("src2", src2, m_pkt.s2);
    end
  endtask

  task automatic cycle(input logic v, input logic [31:0] ins,
                       input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic fl,
                       input logic ordy);
    logic acc;
    logic nv;
    pkt_t np;
    in_valid  = v;
    in_inst   = ins;
    in_pc     = pc;
    rs1_data  = a;
    rs2_data  = b;
    flush     = fl;
    out_ready = ordy;
    #1;
    chk("in_ready", in_ready, !m_valid || ordy);
    chk("rs1_addr", rs1_addr, ins[19:15]);
    chk("rs2_addr", rs2_addr, ins[24:20]);
    acc = v && (!m_valid || ordy) && !fl;
    np  = ref_decode(ins, pc, a, b);
    if (fl)        nv = 1'b0;
    else if (acc)  nv = 1'b1;
    else if (ordy) nv = 1'b0;
    else           nv = m_valid;
    @(posedge clk);
    m_valid = nv;
    if (acc) m_pkt = np;
    @(negedge clk);
    compare();
  endtask

  function automatic logic [31:0] gen_inst();
    logic [31:0] r;
    logic [6:0]  opcs [11];
    int          k;
    int          s;
    opcs = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h23,
             7'h63, 7'h13, 7'h33, 7'h13, 7'h33};
    r = $urandom;
    k = $urandom_range(0, 12);
    if (k < 11) begin
      r[6:0] = opcs[k];
      if (k >= 7) begin
        s = $urandom_range(0, 3);
        if (s < 2)       r[31:25] = 7'h00;
        else if (s == 2) r[31:25] = 7'h20;
      end
    end else if (k == 11) begin
      r = 32'h0010_0073;
    end
    return r;
  endfunction

  localparam logic [31:0] PC0 = 32'h8000_0000;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_pc     = '0;
    rs1_data  = '0;
    rs2_data  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    m_valid   = 1'b0;
    m_pkt     = reset_pkt();
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_pc", out_pc, 32'h8000_0000);
    chk("rst_src1", src1, 0);
    chk("rst_src2", src2, 0);
    chk("rst_alu", alu_opcode, 0);
    chk("rst_rd", rd, 0);
    chk("rst_wen", wen, 0);
    chk("rst_illegal", illegal, 0);
    rst_n = 1'b1;

    cycle(1, 32'h0050_0093, PC0, 0, 0, 0, 1);
    chk("addi_valid", out_valid, 1);
    chk("addi_op", alu_opcode, 8'h80);
    chk("addi_src1", src1, 0);
    chk("addi_src2", src2, 5);
    chk("addi_rd", rd, 1);
    chk("addi_wen", wen, 1);
    chk("addi_sub", alu_sub, 0);

    cycle(1, 32'h4020_81B3, PC0 + 4, 7, 3, 0, 1);
    chk("sub_op", alu_opcode, 8'h80);
    chk("sub_sub", alu_sub, 1);
    chk("sub_src1", src1, 7);
    chk("sub_src2", src2, 3);
    chk("sub_rd", rd, 3);

    cycle(1, 32'h4043_5293, PC0 + 8, 32'hF000_0000, 0, 0, 1);
    chk("srai_op", alu_opcode, 8'h10);
    chk("srai_arith", alu_arith, 1);
    chk("srai_src1", src1, 32'hF000_0000);
    chk("srai_src2", src2, 4);

    cycle(1, 32'h1234_53B7, PC0 + 12, 0, 0, 0, 1);
    chk("lui_op", alu_opcode, 8'h08);
    chk("lui_src2", src2, 32'h1234_5000);
    chk("lui_wen", wen, 1);

    cycle(1, 32'hFFFF_FFFF, PC0 + 16, 0, 0, 0, 1);
    chk("ill_flag", illegal, 1);
    chk("ill_op", alu_opcode, 0);
    chk("ill_wen", wen, 0);
    chk("ill_valid", out_valid, 1);

    cycle(1, 32'h0010_0073, PC0 + 20, 0, 0, 0, 1);
    chk("ebreak_flag", ebreak, 1);
    chk("ebreak_op", alu_opcode, 0);
    chk("ebreak_wen", wen, 0);

    cycle(1, 32'h0000_0013, PC0 + 24, 0, 0, 0, 1);
    chk("x0_wen", wen, 0);

    cycle(1, 32'h0050_0093, PC0 + 28, 0, 0, 0, 1);
    repeat (3) begin
      cycle(1, 32'h1234_53B7, PC0 + 32, 0, 0, 0, 0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_src2", src2, 5);
      chk("bp_hold_pc", out_pc, PC0 + 28);
    end
    cycle(1, 32'h1234_53B7, PC0 + 32, 0, 0, 0, 1);
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_op", alu_opcode, 8'h08);
    chk("bp_next_pc", out_pc, PC0 + 32);

    cycle(1, 32'h0050_0093, PC0 + 36, 0, 0, 0, 0);
    cycle(1, 32'h4020_81B3, PC0 + 40, 1, 1, 1, 0);
    chk("flush_valid", out_valid, 0);

    cycle(1, 32'h0050_0093, PC0 + 44, 0, 0, 0, 1);
    cycle(0, 32'h0, PC0, 0, 0, 0, 0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_pc", out_pc, 32'h8000_0000);
    m_valid = 1'b0;
    m_pkt   = reset_pkt();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, gen_inst(),
            $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
            $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
